dhtxx_sampler: RTL and testbench

DHTXX_SAMPLER -- requirements
Module: dhtxx_sampler

---
 rtl/dht_pkg.sv | 39 +++
 rtl/dht_line_sync.sv | 38 +++
 rtl/dhtxx_sampler.sv | 234 +++++++++++++++++++++++
 tb/tb_dhtxx_sampler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dht_pkg.sv
// Shared types and microsecond timing constants for the DHT11/DHT22 sampler.
package dht_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_HOLDOFF,
        ST_START_LOW,
        ST_RELEASE,
        ST_RESP_LOW,
        ST_RESP_HIGH,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_CHECK
    } dht_state_e;

    typedef enum logic [1:0] {
        ERR_OK          = 2'd0,
        ERR_NO_RESP     = 2'd1,
        ERR_BIT_TIMEOUT = 2'd2,
        ERR_CHECKSUM    = 2'd3
    } dht_err_e;

    localparam int unsigned START_DHT11_US = 18000;
    localparam int unsigned START_DHT22_US = 1100;
    localparam int unsigned RELEASE_US     = 30;
    localparam int unsigned HOLDOFF_US     = 1_000_000;

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Frame is {hum_hi, hum_lo, tmp_hi, tmp_lo, sum}; sum is the byte-wise 8-bit total.
    function automatic logic dht_checksum_ok(input logic [39:0] frame);
        logic [7:0] sum;
        sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
        return sum == frame[7:0];
    endfunction

endpackage

// File: rtl/dht_line_sync.sv
// Two-flop synchroniser for the sensor line plus rise/fall detection on the synchronised level.
module dht_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_s,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = line_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Idle bus is pulled high, so reset to the released level to avoid a phantom edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign line_s = sync_q;
    assign rise   = sync_q & ~prev_q;
    assign fall   = ~sync_q & prev_q;

endmodule

// File: rtl/dhtxx_sampler.sv
// Single-wire DHT11/DHT22 reader: start pulse, response handshake, 40-bit capture and checksum.
//   state      | meaning
//   IDLE       | waiting for start or period expiry
//   START_LOW  | host drives line low (18 ms / 1.1 ms)
//   RELEASE    | line high-Z before sensor answers
//   RESP_LOW   | wait for sensor to pull low
//   RESP_HIGH  | wait for sensor high, then low (bit 0 begins)
//   BIT_LOW    | low preamble of a data bit
//   BIT_HIGH   | measure high length, decide bit on falling edge
//   CHECK      | verify checksum, publish frame
//   HOLDOFF    | mandatory rest with line released
module dhtxx_sampler
    import dht_pkg::*;
#(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned PERIOD_MS     = 2000,
    parameter int unsigned BIT_THRESH_US = 50,
    parameter int unsigned TIMEOUT_US    = 200,
    parameter int unsigned HOLD_US       = HOLDOFF_US
) (
    input  logic        CLK,
    input  logic        RST,
    inout  wire         DHT_data,
    input  logic        mode,
    input  logic        start,
    output logic        busy,
    output logic        valid,
    output logic [15:0] hum,
    output logic [15:0] tmp,
    output logic [1:0]  err,
    output logic        err_strobe
);

    localparam int unsigned CPU      = CLK_HZ / 1_000_000;
    localparam int unsigned C_START0 = CPU * START_DHT11_US;
    localparam int unsigned C_START1 = CPU * START_DHT22_US;
    localparam int unsigned C_REL    = CPU * RELEASE_US;
    localparam int unsigned C_HOLD   = CPU * HOLD_US;
    localparam int unsigned C_TO     = CPU * TIMEOUT_US;
    localparam int unsigned C_THR    = CPU * BIT_THRESH_US;
    localparam int unsigned C_PER    = CPU * PERIOD_MS * 1000;
    localparam int unsigned C_MAX    = umax(umax(umax(C_START0, C_HOLD), umax(C_PER, C_TO)), C_REL);
    localparam int          TW       = $clog2(C_MAX + 1);

    localparam logic [TW-1:0] L_START0 = TW'(C_START0 - 1);
    localparam logic [TW-1:0] L_START1 = TW'(C_START1 - 1);
    localparam logic [TW-1:0] L_REL    = TW'(C_REL - 1);
    localparam logic [TW-1:0] L_HOLD   = TW'(C_HOLD - 1);
    localparam logic [TW-1:0] L_TO     = TW'(C_TO - 1);
    localparam logic [TW-1:0] L_PER    = (C_PER == 0) ? '0 : TW'(C_PER - 1);
    // Timer counts down from L_TO in BIT_HIGH, so high length = C_TO - tmr at the falling edge.
    localparam logic [TW-1:0] L_BIT1   = TW'(C_TO - C_THR);

    logic line_s, rise_s, fall_s;

    dht_line_sync u_sync (
        .clk     (CLK),
        .rst     (RST),
        .line_in (DHT_data),
        .line_s  (line_s),
        .rise    (rise_s),
        .fall    (fall_s)
    );

    dht_state_e    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [TW-1:0] per_q, per_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [39:0]   shift_q, shift_d;
    logic          seen_high_q, seen_high_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic          err_strobe_q, err_strobe_d;
    dht_err_e      err_q, err_d;
    logic [15:0]   hum_q, hum_d;
    logic [15:0]   tmp_q, tmp_d;
    logic          drive_low_q, drive_low_d;
    logic          fail;
    dht_err_e      fail_code;

    always_comb begin
        state_d      = state_q;
        tmr_d        = (tmr_q != '0) ? tmr_q - 1'b1 : tmr_q;
        per_d        = (per_q == '0) ? L_PER : per_q - 1'b1;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        seen_high_d  = seen_high_q;
        valid_d      = 1'b0;
        err_strobe_d = 1'b0;
        err_d        = err_q;
        hum_d        = hum_q;
        tmp_d        = tmp_q;
        fail         = 1'b0;
        fail_code    = ERR_OK;

        case (state_q)
            ST_IDLE: begin
                if (start || (C_PER != 0 && per_q == '0)) begin
                    state_d   = ST_START_LOW;
                    tmr_d     = mode ? L_START1 : L_START0;
                    per_d     = L_PER;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            ST_START_LOW: begin
                if (tmr_q == '0) begin
                    state_d = ST_RELEASE;
                    tmr_d   = L_REL;
                end
            end
            ST_RELEASE: begin
                if (tmr_q == '0) begin
                    state_d = ST_RESP_LOW;
                    tmr_d   = L_TO;
                end
            end
            ST_RESP_LOW: begin
                if (!line_s) begin
                    state_d     = ST_RESP_HIGH;
                    tmr_d       = L_TO;
                    seen_high_d = 1'b0;
                end else if (tmr_q == '0) begin
                    fail      = 1'b1;
                    fail_code = ERR_NO_RESP;
                end
            end
            ST_RESP_HIGH: begin
                if (!seen_high_q && rise_s) begin
                    seen_high_d = 1'b1;
                    tmr_d       = L_TO;
                end else if (seen_high_q && fall_s) begin
                    state_d = ST_BIT_LOW;
                    tmr_d   = L_TO;
                end else if (tmr_q == '0) begin
                    fail      = 1'b1;
                    fail_code = ERR_NO_RESP;
                end
            end
            ST_BIT_LOW: begin
                if (rise_s) begin
                    state_d = ST_BIT_HIGH;
                    tmr_d   = L_TO;
                end else if (tmr_q == '0) begin
                    fail      = 1'b1;
                    fail_code = ERR_BIT_TIMEOUT;
                end
            end
            ST_BIT_HIGH: begin
                if (fall_s) begin
                    shift_d = {shift_q[38:0], (tmr_q < L_BIT1)};
                    tmr_d   = L_TO;
                    if (bit_cnt_q == 6'd39) begin
                        state_d = ST_CHECK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 6'd1;
                        state_d   = ST_BIT_LOW;
                    end
                end else if (tmr_q == '0) begin
                    fail      = 1'b1;
                    fail_code = ERR_BIT_TIMEOUT;
                end
            end
            ST_CHECK: begin
                state_d = ST_HOLDOFF;
                tmr_d   = L_HOLD;
                if (dht_checksum_ok(shift_q)) begin
                    hum_d   = shift_q[39:24];
                    tmp_d   = shift_q[23:8];
                    valid_d = 1'b1;
                    err_d   = ERR_OK;
                end else begin
                    err_d        = ERR_CHECKSUM;
                    err_strobe_d = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (tmr_q == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (fail) begin
            state_d      = ST_HOLDOFF;
            tmr_d        = L_HOLD;
            err_d        = fail_code;
            err_strobe_d = 1'b1;
        end

        busy_d      = (state_d != ST_IDLE);
        drive_low_d = (state_d == ST_START_LOW);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            per_q        <= L_PER;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            seen_high_q  <= 1'b0;
            busy_q       <= 1'b0;
            valid_q      <= 1'b0;
            err_strobe_q <= 1'b0;
            err_q        <= ERR_OK;
            hum_q        <= '0;
            tmp_q        <= '0;
            drive_low_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            per_q        <= per_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            seen_high_q  <= seen_high_d;
            busy_q       <= busy_d;
            valid_q      <= valid_d;
            err_strobe_q <= err_strobe_d;
            err_q        <= err_d;
            hum_q        <= hum_d;
            tmp_q        <= tmp_d;
            drive_low_q  <= drive_low_d;
        end
    end

    assign DHT_data   = drive_low_q ? 1'b0 : 1'bz;
    assign busy       = busy_q;
    assign valid      = valid_q;
    assign err_strobe = err_strobe_q;
    assign err        = err_q;
    assign hum        = hum_q;
    assign tmp        = tmp_q;

endmodule

// File: tb/tb_dhtxx_sampler.sv
// Directed bench for dhtxx_sampler with a behavioural sensor; 1 MHz clock so one cycle is one microsecond.
module tb_dhtxx_sampler;

    localparam int unsigned CLK_HZ    = 1_000_000;
    localparam int unsigned PERIOD_MS = 25;
    localparam int unsigned HOLD_US   = 1000;
    localparam int          PER_CYC   = 25000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b1;
    logic        start = 1'b0;
    logic        sens_low = 1'b0;
    wire         dht_line;
    logic        busy, valid, err_strobe;
    logic [15:0] hum, tmp;
    logic [1:0]  err;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    int estr_cnt = 0;

    pullup (dht_line);
    assign dht_line = sens_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid === 1'b1) valid_cnt++;
        if (err_strobe === 1'b1) estr_cnt++;
    end

    dhtxx_sampler #(
        .CLK_HZ        (CLK_HZ),
        .PERIOD_MS     (PERIOD_MS),
        .BIT_THRESH_US (50),
        .TIMEOUT_US    (200),
        .HOLD_US       (HOLD_US)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .DHT_data   (dht_line),
        .mode       (mode),
        .start      (start),
        .busy       (busy),
        .valid      (valid),
        .hum        (hum),
        .tmp        (tmp),
        .err        (err),
        .err_strobe (err_strobe)
    );

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic measure_low(output int n);
        n = 0;
        while (dht_line === 1'b0 && n < 30000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Sensor: answer the host start, then send 40 bits MSB-first. stall_bit holds the
    // line high 300 us at that bit; stop_bit returns just before that bit begins.
    task automatic sensor_run(input logic [39:0] frame, input int stall_bit, input int stop_bit,
                              output int low_len, output bit got);
        int w;
        got = 1'b0;
        low_len = 0;
        w = 0;
        while (dht_line !== 1'b0 && w < 30000) begin
            w++;
            @(negedge clk);
        end
        if (dht_line !== 1'b0) return;
        measure_low(low_len);
        got = 1'b1;
        repeat (30) @(negedge clk);
        sens_low = 1'b1; repeat (80) @(negedge clk);
        sens_low = 1'b0; repeat (80) @(negedge clk);
        for (int b = 0; b < 40; b++) begin
            if (b == stop_bit) return;
            sens_low = 1'b1; repeat (50) @(negedge clk);
            sens_low = 1'b0;
            if (b == stall_bit) begin
                repeat (300) @(negedge clk);
                return;
            end
            repeat (frame[39-b] ? 70 : 26) @(negedge clk);
        end
        sens_low = 1'b1; repeat (50) @(negedge clk);
        sens_low = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s idle_timeout: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (valid !== 1'b0)      begin errors++; $display("FAIL reset_valid: got %b required 0", valid); end
        checks++; if (err_strobe !== 1'b0) begin errors++; $display("FAIL reset_err_strobe: got %b required 0", err_strobe); end
        checks++; if (err !== 2'd0)        begin errors++; $display("FAIL reset_err: got %0d required 0", err); end
        checks++; if (hum !== 16'h0000)    begin errors++; $display("FAIL reset_hum: got %h required 0000", hum); end
        checks++; if (tmp !== 16'h0000)    begin errors++; $display("FAIL reset_tmp: got %h required 0000", tmp); end
        checks++; if (dht_line !== 1'b1)   begin errors++; $display("FAIL reset_line: got %b required 1", dht_line); end
        rst = 1'b0;
        mode = 1'b1;
        pulse_start();
        repeat (10) @(negedge clk);
        checks++; if (dht_line !== 1'b0) begin errors++; $display("FAIL start_low_line: got %b required 0", dht_line); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL start_low_busy: got %b required 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (dht_line !== 1'b1) begin errors++; $display("FAIL rst_release_line: got %b required 1", dht_line); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_clear_busy: got %b required 0", busy); end
    endtask

    task automatic test_auto_no_sensor();
        int k, low_len, j, bad;
        @(negedge clk) rst = 1'b0;
        k = 0;
        while (busy !== 1'b1 && k < PER_CYC + 1000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== PER_CYC) begin errors++; $display("FAIL auto_period: busy rose at %0d required %0d", k, PER_CYC); end
        measure_low(low_len);
        checks++;
        if (low_len !== 1100) begin errors++; $display("FAIL auto_start_len: got %0d required 1100", low_len); end
        k = 0;
        while (err_strobe !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k < 225 || k > 230) begin errors++; $display("FAIL no_resp_time: strobe at %0d required 225..230", k); end
        checks++;
        if (err !== 2'd1) begin errors++; $display("FAIL no_resp_err: got %0d required 1", err); end
        j = 0;
        while (busy !== 1'b0 && j < 3000) begin
            start = (j == 500);
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        checks++;
        if (j !== HOLD_US) begin errors++; $display("FAIL holdoff_len: got %0d required %0d", j, HOLD_US); end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b0 || dht_line !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL holdoff_start_ignored: %0d busy cycles required 0", bad); end
    endtask

    task automatic test_frame(input string name, input logic m, input logic [39:0] frame,
                              input int exp_low, input int exp_valid, input logic [1:0] exp_err,
                              input logic [15:0] exp_hum, input logic [15:0] exp_tmp);
        int low_len, v0, e0;
        bit got;
        v0 = valid_cnt;
        e0 = estr_cnt;
        mode = m;
        pulse_start();
        sensor_run(frame, -1, -1, low_len, got);
        checks++; if (got !== 1'b1)       begin errors++; $display("FAIL %s host_start: got %b required 1", name, got); end
        checks++; if (low_len !== exp_low) begin errors++; $display("FAIL %s start_len: got %0d required %0d", name, low_len, exp_low); end
        wait_idle(2000, name);
        checks++; if (valid_cnt - v0 !== exp_valid) begin errors++; $display("FAIL %s valid_pulses: got %0d required %0d", name, valid_cnt - v0, exp_valid); end
        checks++; if (estr_cnt - e0 !== 1 - exp_valid) begin errors++; $display("FAIL %s err_strobes: got %0d required %0d", name, estr_cnt - e0, 1 - exp_valid); end
        checks++; if (err !== exp_err)  begin errors++; $display("FAIL %s err: got %0d required %0d", name, err, exp_err); end
        checks++; if (hum !== exp_hum)  begin errors++; $display("FAIL %s hum: got %h required %h", name, hum, exp_hum); end
        checks++; if (tmp !== exp_tmp)  begin errors++; $display("FAIL %s tmp: got %h required %h", name, tmp, exp_tmp); end
    endtask

    task automatic test_bit_timeout();
        int low_len, v0, e0;
        bit got;
        v0 = valid_cnt;
        e0 = estr_cnt;
        mode = 1'b1;
        pulse_start();
        sensor_run(40'h02_8C_01_0F_9E, 12, -1, low_len, got);
        wait_idle(2000, "bit_timeout");
        checks++; if (err !== 2'd2) begin errors++; $display("FAIL bit_timeout_err: got %0d required 2", err); end
        checks++; if (estr_cnt - e0 !== 1) begin errors++; $display("FAIL bit_timeout_strobe: got %0d required 1", estr_cnt - e0); end
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL bit_timeout_valid: got %0d required 0", valid_cnt - v0); end
        checks++; if (hum !== 16'h028C) begin errors++; $display("FAIL bit_timeout_hum: got %h required 028c", hum); end
    endtask

    task automatic test_reset_mid_frame();
        int low_len, v0;
        bit got;
        v0 = valid_cnt;
        mode = 1'b1;
        pulse_start();
        sensor_run(40'h02_8C_01_0F_9E, -1, 20, low_len, got);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b required 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL mid_rst_busy: got %b required 0", busy); end
        checks++; if (dht_line !== 1'b1) begin errors++; $display("FAIL mid_rst_line: got %b required 1", dht_line); end
        checks++; if (hum !== 16'h0000)  begin errors++; $display("FAIL mid_rst_hum: got %h required 0000", hum); end
        checks++; if (err !== 2'd0)      begin errors++; $display("FAIL mid_rst_err: got %0d required 0", err); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after: got %b required 0", busy); end
        checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL mid_valid: got %0d required 0", valid_cnt - v0); end
    endtask

    initial begin
        test_reset();
        test_auto_no_sensor();
        test_frame("dht11", 1'b0, 40'h37_00_19_00_50, 18000, 1, 2'd0, 16'h3700, 16'h1900);
        test_frame("dht22", 1'b1, 40'h02_8C_01_0F_9E, 1100, 1, 2'd0, 16'h028C, 16'h010F);
        test_frame("checksum", 1'b1, 40'h37_00_19_00_51, 1100, 0, 2'd3, 16'h028C, 16'h010F);
        test_bit_timeout();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
